// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, synchronous imem reader, 2-entry fetch queue
// and valid/ready hand-off to the core, with redirect flush and halt logic.
//
// Ports:
//   clk, rst            rising-edge clock, async active-low reset
//   imem_rd_en/addr     read strobe and word address; data back 1 cycle later
//   imem_rdata          instruction word from memory
//   redirect_valid/pc   one-cycle restart request from execute
//   instr_valid/ready   handshake for the head-of-queue entry
//   instr, instr_pc     head-of-queue word and its PC
//   halted              fetch stopped for good (ebreak, range end, misalign)
//   misalign_err        sticky flag for a redirect target with pc[1:0] != 0
module instr_fetch_unit #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_DEPTH = 256,
  parameter int              AW         = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_rd_en,
  output logic [AW-1:0]   imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            halted,
  output logic            misalign_err
);

  localparam logic [XLEN:0] LIMIT = (XLEN+1)'(IMEM_DEPTH) << 2;
  localparam logic [31:0]   EBRK  = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_infl_pc;
  logic            r_infl_ep;
  logic            r_epoch;
  logic [31:0]     r_q_ins [2];
  logic [XLEN-1:0] r_q_pc  [2];
  logic            r_head;
  logic [1:0]      r_count;
  logic            r_ebrk;
  logic            r_ebrk_done;
  logic            r_halted;
  logic            r_misalign;

  logic       w_in_range;
  logic       w_pop;
  logic       w_redir;
  logic       w_misal;
  logic       w_push;
  logic [2:0] w_occ;
  logic       w_issue;
  logic       w_tail;

  // One extra bit so a memory reaching 2^XLEN bytes still compares right.
  assign w_in_range = {1'b0, r_pc} < LIMIT;
  assign w_pop      = instr_valid && instr_ready;

  // Once the ebreak has been handed over the stream is final.
  assign w_redir = redirect_valid
                && (r_state != S_HALT)
                && !r_ebrk_done;
  assign w_misal = w_redir && (redirect_pc[1:0] != 2'b00);

  // Stale-epoch responses and anything younger than an ebreak are dropped.
  assign w_push = r_inflight
               && (r_infl_ep == r_epoch)
               && !w_redir
               && !r_ebrk;

  // Counting this cycle's pop keeps one-per-cycle throughput.
  assign w_occ = {1'b0, r_count}
               + {2'b00, r_inflight}
               - {2'b00, w_pop};

  // rst gates the strobe so nothing is requested while reset is held.
  assign w_issue = rst
                && (r_state == S_FETCH)
                && !w_redir
                && w_in_range
                && (w_occ < 3'd2);

  // Tail slot; at count 2 it is the head slot being freed by the pop.
  assign w_tail = r_head ^ r_count[0];

  assign imem_rd_en   = w_issue;
  assign imem_addr    = w_issue ? r_pc[AW+1:2] : '0;
  assign instr_valid  = (r_count != 2'd0);
  assign instr        = r_q_ins[r_head];
  assign instr_pc     = r_q_pc[r_head];
  assign halted       = r_halted;
  assign misalign_err = r_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_inflight  <= 1'b0;
      r_infl_pc   <= '0;
      r_infl_ep   <= 1'b0;
      r_epoch     <= 1'b0;
      r_q_ins[0]  <= '0;
      r_q_ins[1]  <= '0;
      r_q_pc[0]   <= '0;
      r_q_pc[1]   <= '0;
      r_head      <= 1'b0;
      r_count     <= 2'd0;
      r_ebrk      <= 1'b0;
      r_ebrk_done <= 1'b0;
      r_halted    <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc      <= r_pc + XLEN'(4);
        r_infl_pc <= r_pc;
        r_infl_ep <= r_epoch;
      end
      if (w_redir) begin
        r_epoch <= ~r_epoch;
        r_count <= 2'd0;
        r_head  <= 1'b0;
        r_ebrk  <= 1'b0;
        r_pc    <= redirect_pc;
        if (w_misal) begin
          r_misalign <= 1'b1;
          r_halted   <= 1'b1;
          r_state    <= S_HALT;
        end else begin
          r_state <= S_FETCH;
        end
      end else begin
        if (w_push) begin
          r_q_ins[w_tail] <= imem_rdata;
          r_q_pc[w_tail]  <= r_infl_pc;
        end
        if (w_pop) begin
          r_head <= ~r_head;
        end
        r_count <= r_count
                 + {1'b0, w_push}
                 - {1'b0, w_pop};
        if (w_push && imem_rdata == EBRK) begin
          r_ebrk <= 1'b1;
        end
        // The ebreak is always the youngest entry, so count 1 means it.
        if (w_pop && r_ebrk && r_count == 2'd1) begin
          r_ebrk_done <= 1'b1;
        end
        case (r_state)
          S_FETCH: begin
            if (w_push && imem_rdata == EBRK) begin
              r_state <= S_DRAIN;
            end else if (!w_in_range) begin
              r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (r_count == 2'd0 && !r_inflight) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
          end
          S_HALT: begin
            r_state <= S_HALT;
          end
          default: begin
            r_state <= S_HALT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit with a
// program-order stream model, directed scenarios and random runs.
module tb_instr_fetch_unit;

  localparam int          XLEN  = 64;
  localparam int          DEPTH = 16;
  localparam int          AW    = 4;
  localparam logic [31:0] EBRK  = 32'h0010_0073;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            imem_rd_en;
  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_rdata = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            instr_valid;
  logic            instr_ready = 1'b0;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            halted;
  logic            misalign_err;

  logic [31:0] mem [DEPTH];
  exp_t        sb [$];
  int          hs_cyc [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          base = 0;

  instr_fetch_unit #(
    .XLEN(XLEN),
    .RESET_PC(64'h0),
    .IMEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_rd_en(imem_rd_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .halted(halted),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: every accepted entry must be the next one of the model stream.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc %h expected none",
                 instr_pc);
      end else begin
        e = sb.pop_front();
        check("instr_pc", instr_pc, e.pc);
        check("instr", {32'b0, instr}, {32'b0, e.ins});
      end
      hs_cyc.push_back(cyc - base);
    end
    if (rst && halted) begin
      check("halted_quiet", {62'b0, imem_rd_en, instr_valid}, 64'd0);
    end
  end

  // Program-order stream from start: stops after an ebreak or at range end.
  task automatic load_stream(input logic [63:0] start);
    logic [63:0] pc;
    int          idx;
    pc = start;
    while (pc < 64'(DEPTH * 4)) begin
      idx = int'(pc / 4);
      sb.push_back('{pc: pc, ins: mem[idx]});
      if (mem[idx] == EBRK) break;
      pc += 64'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_plain();
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom();
      if (w == EBRK) w = w ^ 32'h1;
      mem[i] = w;
    end
  endtask

  task automatic fill_prog();
    fill_plain();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00a0_0113;
    mem[2] = 32'h0020_81b3;
    mem[3] = EBRK;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"}, {63'b0, imem_rd_en}, 64'd0);
    check({tag, "_addr"}, {60'b0, imem_addr}, 64'd0);
    check({tag, "_valid"}, {63'b0, instr_valid}, 64'd0);
    check({tag, "_instr"}, {32'b0, instr}, 64'd0);
    check({tag, "_pc"}, instr_pc, 64'd0);
    check({tag, "_halted"}, {63'b0, halted}, 64'd0);
    check({tag, "_misalign"}, {63'b0, misalign_err}, 64'd0);
  endtask

  task automatic start_run();
    rst = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step();
    step();
    sb.delete();
    hs_cyc.delete();
    load_stream(64'd0);
    rst = 1'b1;
    base = cyc;
  endtask

  task automatic do_redirect(input logic [63:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    step();
    redirect_valid = 1'b0;
    sb.delete();
    if (t[1:0] == 2'b00) load_stream(t);
  endtask

  task automatic wait_halt(input int budget);
    int i;
    i = 0;
    while (!halted && i < budget) begin
      step();
      i++;
    end
    check("halt_reached", {63'b0, halted}, 64'd1);
    check("all_delivered", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] t;
    int          i;

    // Reset values
    fill_prog();
    step();
    step();
    check_zero("reset");

    // Sequential run to ebreak at full throughput
    start_run();
    instr_ready = 1'b1;
    do @(negedge clk); while (cyc - base < 6);
    check("halted_c6", {63'b0, halted}, 64'd0);
    @(negedge clk);
    check("halted_c7", {63'b0, halted}, 64'd1);
    check("seq_count", 64'(hs_cyc.size()), 64'd4);
    check("seq_first_cyc", 64'(hs_cyc[0]), 64'd2);
    check("seq_last_cyc", 64'(hs_cyc[3]), 64'd5);
    step();
    wait_halt(50);

    // Backpressure: head held, strobe off with two buffered
    fill_prog();
    start_run();
    do @(negedge clk); while (cyc - base < 2);
    for (int k = 0; k < 5; k++) begin
      check("bp_instr", {32'b0, instr}, 64'h0050_0093);
      check("bp_pc", instr_pc, 64'd0);
      check("bp_rd_en", {63'b0, imem_rd_en}, 64'd0);
      if (k < 4) @(negedge clk);
    end
    step();
    instr_ready = 1'b1;
    wait_halt(50);

    // Redirect while the queue holds PCs 4 and 8
    fill_plain();
    start_run();
    instr_ready = 1'b1;
    step();
    step();
    step();
    instr_ready = 1'b0;
    step();
    check("pre_redir_head", instr_pc, 64'd4);
    do_redirect(64'h20);
    instr_ready = 1'b1;
    wait_halt(100);
    check("redir_count", 64'(hs_cyc.size()), 64'(1 + DEPTH - 8));

    // Misaligned redirect, then redirects are ignored
    fill_plain();
    start_run();
    instr_ready = 1'b1;
    step();
    step();
    step();
    do_redirect(64'h22);
    check("mis_err", {63'b0, misalign_err}, 64'd1);
    check("mis_halted", {63'b0, halted}, 64'd1);
    do_redirect(64'h10);
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      check("mis_rd_en", {63'b0, imem_rd_en}, 64'd0);
      step();
    end
    check("mis_still_halted", {63'b0, halted}, 64'd1);

    // Range end without ebreak
    fill_plain();
    start_run();
    instr_ready = 1'b1;
    wait_halt(100);
    check("range_count", 64'(hs_cyc.size()), 64'(DEPTH));

    // Async reset mid-stream, then restart at RESET_PC
    fill_plain();
    start_run();
    step();
    step();
    step();
    check("pre_reset_valid", {63'b0, instr_valid}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async");
    start_run();
    instr_ready = 1'b1;
    wait_halt(100);

    // Random runs: random program, ready pattern and redirects
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] = ($urandom_range(0, 11) == 0) ? EBRK : $urandom();
      end
      start_run();
      i = 0;
      while (!halted && i < 600) begin
        instr_ready = ($urandom_range(0, 3) != 0);
        if (sb.size() > 0 && $urandom_range(0, 15) == 0) begin
          t = 64'($urandom_range(0, DEPTH + 1)) << 2;
          do_redirect(t);
        end else begin
          step();
        end
        i++;
      end
      instr_ready = 1'b1;
      wait_halt(200);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
